// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared constants, slot/page types and one-hot helper for the slot selector
package slot_pkg;

  localparam logic [7:0]  IO_PSLOT    = 8'hA8;
  localparam logic [15:0] ADDR_SSR    = 16'hFFFF;
  localparam logic [7:0]  IO_MAP_BASE = 8'hFC;

  typedef logic [1:0] page_t;

  typedef struct packed {
    logic [1:0] pslot;
    logic [1:0] sslot;
  } slot_id_t;

  function automatic logic [15:0] slot_onehot(input slot_id_t id);
    logic [3:0] idx;
    idx = id;
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/slot_busy_guard.sv
// rtl/slot_busy_guard.sv - holds the CPU in wait for a fixed guard after a new target is selected
module slot_busy_guard #(
  parameter int GUARD_CYC = 2
) (
  input  logic i_CLK,
  input  logic i_RST_n,
  input  logic i_ACTIVE,
  input  logic i_TGT_BUSY,
  output logic o_BUSY
);

  logic       active_q;
  logic [3:0] cnt_q;

  // Counter loads only on the select rising edge, so a held select never retriggers.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      active_q <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      active_q <= i_ACTIVE;
      if (!i_ACTIVE)
        cnt_q <= 4'd0;
      else if (!active_q)
        cnt_q <= 4'(GUARD_CYC);
      else if (cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
    end
  end

  assign o_BUSY = ((cnt_q != 4'd0) & i_ACTIVE) | i_TGT_BUSY;

endmodule

// File: rtl/slot_select_unit.sv
// rtl/slot_select_unit.sv - primary/secondary slot decoder with busy guard; SLOT_SELECT_MAPPER_EN adds the page mapper
module slot_select_unit
  import slot_pkg::*;
#(
  parameter logic [3:0] EXP_MASK  = 4'b1000,
  parameter int         MAP_W     = 3,
  parameter int         GUARD_CYC = 2
) (
  input  logic             i_CLK,
  input  logic             i_RST_n,
  input  logic             i_IORQ,
  input  logic             i_MERQ,
  input  logic             i_RD,
  input  logic             i_WR,
  input  logic [15:0]      i_A,
  input  logic [7:0]       i_WDATA,
  output logic [7:0]       o_RDATA,
  output logic             o_RDATA_OE,
  output logic [15:0]      o_SEL,
  output logic [1:0]       o_PAGE,
  output logic [MAP_W-1:0] o_MAP_SEG,
  input  logic [15:0]      i_TGT_BUSY,
  output logic             o_BUSY
);

  logic [7:0] psr_q;
  logic [7:0] ssr_q [4];
  page_t      pg;
  logic [1:0] p3;
  logic       psr_hit, ssr_hit, map_hit;
  logic       wr_req, wr_q1, wr_q2, wr_pulse;
  slot_id_t   mem_id;

  assign pg     = i_A[15:14];
  assign o_PAGE = pg;
  assign p3     = psr_q[7:6];

  // I/O always beats memory, so the FFFFh intercept requires i_IORQ low.
  assign psr_hit = i_IORQ & (i_A[7:0] == IO_PSLOT);
  assign ssr_hit = i_MERQ & ~i_IORQ & EXP_MASK[p3] & (i_A == ADDR_SSR);

  always_comb begin
    mem_id.pslot = psr_q[{pg, 1'b0} +: 2];
    mem_id.sslot = EXP_MASK[mem_id.pslot] ? ssr_q[mem_id.pslot][{pg, 1'b0} +: 2] : 2'b00;
  end

  assign o_SEL = (i_RST_n & i_MERQ & ~i_IORQ & ~ssr_hit) ? slot_onehot(mem_id) : 16'h0000;

  // One register write per access: fire on the registered rising edge of the write strobe.
  assign wr_req   = i_WR & (psr_hit | ssr_hit | map_hit);
  assign wr_pulse = wr_q1 & ~wr_q2;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      wr_q1 <= 1'b0;
      wr_q2 <= 1'b0;
      psr_q <= 8'h00;
      for (int i = 0; i < 4; i++) ssr_q[i] <= 8'h00;
    end else begin
      wr_q1 <= wr_req;
      wr_q2 <= wr_q1;
      if (wr_pulse && i_WR && psr_hit) psr_q     <= i_WDATA;
      if (wr_pulse && i_WR && ssr_hit) ssr_q[p3] <= i_WDATA;
    end
  end

`ifdef SLOT_SELECT_MAPPER_EN
  logic [MAP_W-1:0] map_q [4];
  logic [7:0]       map_rd;

  assign map_hit = i_IORQ & (i_A[7:2] == IO_MAP_BASE[7:2]);

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      for (int i = 0; i < 4; i++) map_q[i] <= MAP_W'(3 - i);
    end else if (wr_pulse && i_WR && map_hit) begin
      map_q[i_A[1:0]] <= i_WDATA[MAP_W-1:0];
    end
  end

  always_comb begin
    map_rd = 8'hFF;
    map_rd[MAP_W-1:0] = map_q[i_A[1:0]];
  end

  assign o_MAP_SEG = map_q[pg];
`else
  assign map_hit   = 1'b0;
  assign o_MAP_SEG = MAP_W'(pg);
`endif

  always_comb begin
    o_RDATA    = 8'h00;
    o_RDATA_OE = 1'b0;
    if (i_RST_n && i_RD) begin
      if (psr_hit) begin
        o_RDATA    = psr_q;
        o_RDATA_OE = 1'b1;
      end else if (ssr_hit) begin
        o_RDATA    = ~ssr_q[p3];
        o_RDATA_OE = 1'b1;
      end
`ifdef SLOT_SELECT_MAPPER_EN
      else if (map_hit) begin
        o_RDATA    = map_rd;
        o_RDATA_OE = 1'b1;
      end
`endif
    end
  end

  slot_busy_guard #(.GUARD_CYC(GUARD_CYC)) u_guard (
    .i_CLK      (i_CLK),
    .i_RST_n    (i_RST_n),
    .i_ACTIVE   (|o_SEL),
    .i_TGT_BUSY (|(o_SEL & i_TGT_BUSY)),
    .o_BUSY     (o_BUSY)
  );

endmodule

// File: tb/tb_slot_select_unit.sv
// tb/tb_slot_select_unit.sv - directed vector bench for slot_select_unit (either SLOT_SELECT_MAPPER_EN build)
module tb_slot_select_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iorq, merq, rd, wr;
  logic [15:0] a;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_oe;
  logic [15:0] sel;
  logic [1:0]  page;
  logic [2:0]  map_seg;
  logic [15:0] tgt_busy;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  slot_select_unit dut (
    .i_CLK      (clk),
    .i_RST_n    (rst_n),
    .i_IORQ     (iorq),
    .i_MERQ     (merq),
    .i_RD       (rd),
    .i_WR       (wr),
    .i_A        (a),
    .i_WDATA    (wdata),
    .o_RDATA    (rdata),
    .o_RDATA_OE (rdata_oe),
    .o_SEL      (sel),
    .o_PAGE     (page),
    .o_MAP_SEG  (map_seg),
    .i_TGT_BUSY (tgt_busy),
    .o_BUSY     (busy)
  );

  typedef struct {
    string       name;
    logic        iorq, merq, rd;
    logic [15:0] a;
    logic [15:0] tgt;
    logic [15:0] exp_sel;
    logic        exp_busy;
    logic        exp_oe;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    iorq = 0; merq = 0; rd = 0; wr = 0; a = 16'h0000; wdata = 8'h00; tgt_busy = 16'h0000;
  endtask

  // Strobe held 4 cycles; data flips after the write cycle so a level-triggered write shows up.
  task automatic bus_write(input logic io, input logic mem, input logic [15:0] addr, input logic [7:0] d);
    @(posedge clk); #1;
    iorq = io; merq = mem; wr = 1; a = addr; wdata = d;
    repeat (2) @(posedge clk);
    #1 wdata = ~d;
    repeat (2) @(posedge clk);
    #1 idle();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic io, input logic mem, input logic r, input logic [15:0] addr);
    iorq = io; merq = mem; rd = r; wr = 0; a = addr;
  endtask

  int n;

  initial begin
    idle();
    rst_n = 0;
    // Reset state with a memory read pending: outputs must be quiet.
    drive(0, 1, 1, 16'h4000);
    @(posedge clk); @(negedge clk);
    chk("reset_sel", sel, 16'h0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_oe", rdata_oe, 1'b0);
    @(posedge clk); #1 rst_n = 1; idle();
    @(posedge clk); #1;

    drive(1, 0, 1, 16'h00A8); @(negedge clk);
    chk("reset_psr", rdata, 8'h00);
    chk("reset_psr_oe", rdata_oe, 1'b1);
    // PSR=0 -> page 3 is slot 0 (not expanded): FFFFh is plain memory.
    drive(0, 1, 1, 16'hFFFF); @(negedge clk);
    chk("ffff_unexpanded_sel", sel, 16'h0001);
    chk("ffff_unexpanded_oe", rdata_oe, 1'b0);
    @(posedge clk); #1 idle();

    bus_write(1, 0, 16'h00A8, 8'hC0);
    vecs.push_back('{"psr_read",     1, 0, 1, 16'h00A8, 16'h0000, 16'h0000, 0, 1, 8'hC0});
    vecs.push_back('{"mem_c000",     0, 1, 1, 16'hC000, 16'h0000, 16'h1000, 0, 0, 8'h00});
    vecs.push_back('{"mem_0000",     0, 1, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 8'h00});
    vecs.push_back('{"mem_8000",     0, 1, 1, 16'h8000, 16'h0000, 16'h0001, 0, 0, 8'h00});
    vecs.push_back('{"ssr_read",     0, 1, 1, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 8'hFF});
    vecs.push_back('{"io_beats_mem", 1, 1, 1, 16'hC000, 16'h0000, 16'h0000, 0, 0, 8'h00});
    vecs.push_back('{"tgt_busy_hit", 0, 1, 0, 16'hC000, 16'h1000, 16'h1000, 1, 0, 8'h00});
    vecs.push_back('{"tgt_busy_oth", 0, 1, 0, 16'hC000, 16'h0001, 16'h1000, 0, 0, 8'h00});
    vecs.push_back('{"no_access",    0, 0, 1, 16'h00A8, 16'h0000, 16'h0000, 0, 0, 8'h00});
`ifdef SLOT_SELECT_MAPPER_EN
    vecs.push_back('{"map_fe_reset", 1, 0, 1, 16'h00FE, 16'h0000, 16'h0000, 0, 1, 8'hF9});
`else
    vecs.push_back('{"map_fe_off",   1, 0, 1, 16'h00FE, 16'h0000, 16'h0000, 0, 0, 8'h00});
`endif
    foreach (vecs[i]) begin
      drive(vecs[i].iorq, vecs[i].merq, vecs[i].rd, vecs[i].a);
      tgt_busy = vecs[i].tgt;
      @(negedge clk);
      chk({vecs[i].name, "_sel"}, sel, vecs[i].exp_sel);
      chk({vecs[i].name, "_busy"}, busy, vecs[i].exp_busy);
      chk({vecs[i].name, "_oe"}, rdata_oe, vecs[i].exp_oe);
      chk({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      @(posedge clk); #1 idle();
      @(posedge clk); #1;
    end

    // Secondary slot register in expanded slot 3.
    bus_write(0, 1, 16'hFFFF, 8'h40);
    drive(0, 1, 1, 16'hFFFF); @(negedge clk);
    chk("ssr_rd_inv", rdata, 8'hBF);
    chk("ssr_rd_sel", sel, 16'h0000);
    @(posedge clk); #1 drive(0, 1, 0, 16'hC000); @(negedge clk);
    chk("ssr_c000_sel", sel, 16'h2000);
    @(posedge clk); #1 idle();

    // Simultaneous I/O and memory write at FFFFh must leave SSR[3] alone.
    @(posedge clk); #1;
    iorq = 1; merq = 1; wr = 1; a = 16'hFFFF; wdata = 8'h00;
    @(negedge clk); chk("both_sel", sel, 16'h0000);
    repeat (3) @(posedge clk); #1 idle();
    @(posedge clk); #1 drive(0, 1, 1, 16'hFFFF); @(negedge clk);
    chk("both_ssr_kept", rdata, 8'hBF);
    @(posedge clk); #1 idle();

    // Busy guard: held select, then target busy longer than the guard.
    bus_write(1, 0, 16'h00A8, 8'h00);
    drive(0, 1, 0, 16'h4000);
    n = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (busy) n++; end
    chk("guard_len", n, 2);
    @(posedge clk); #1 idle();
    @(posedge clk); #1;
    drive(0, 1, 0, 16'h4000); tgt_busy = 16'h0001;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (i == 4) tgt_busy = 16'h0000;
    end
    chk("guard_tgt_len", n, 5);
    @(posedge clk); #1 idle();

    // Mapper write/read and segment output.
    bus_write(1, 0, 16'h00FE, 8'h05);
    drive(1, 0, 1, 16'h00FE); @(negedge clk);
`ifdef SLOT_SELECT_MAPPER_EN
    chk("map_fe_rd", rdata, 8'hFD);
    chk("map_fe_oe", rdata_oe, 1'b1);
`else
    chk("map_fe_rd", rdata, 8'h00);
    chk("map_fe_oe", rdata_oe, 1'b0);
`endif
    @(posedge clk); #1 drive(0, 1, 0, 16'h8000); @(negedge clk);
`ifdef SLOT_SELECT_MAPPER_EN
    chk("map_seg_8000", map_seg, 3'd5);
`else
    chk("map_seg_8000", map_seg, 3'd2);
`endif
    chk("page_8000", page, 2'd2);
    @(posedge clk); #1 idle();
    @(posedge clk); #1;

    // Reset pulse inside the guard window.
    bus_write(1, 0, 16'h00A8, 8'h55);
    drive(0, 1, 0, 16'h4000);
    @(posedge clk); @(negedge clk);
    chk("guard_before_rst", busy, 1'b1);
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("guard_after_rst", busy, 1'b0);
    @(posedge clk); #1 idle();
    drive(1, 0, 1, 16'h00A8); @(negedge clk);
    chk("psr_after_rst", rdata, 8'h00);
    @(posedge clk); #1 idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/slot_select_unit.md
SLOT_SELECT_UNIT -- requirements
Module: slot_select_unit

Interface
REQ-001 Parameter EXP_MASK, default 4'b1000, SHALL mark expanded primary slots; bit p=1 means primary slot p is expanded.
REQ-002 Parameter MAP_W, default 3, SHALL set the mapper segment width in bits (range 2..8).
REQ-003 Parameter GUARD_CYC, default 2, SHALL set the busy-guard length in i_CLK cycles (range 1..15).
REQ-004 Clock and reset SHALL be: reset i_RST_n, synchronous, active-low; clock i_CLK.
REQ-005 Ports SHALL be (name direction width meaning):
  i_CLK  in  1  system clock
  i_RST_n  in  1  sync active-low reset
  i_IORQ / i_MERQ  in  1 each  I/O request / memory request
  i_RD / i_WR  in  1 each  read / write strobes, held multiple cycles
  i_A  in  16  CPU address
  i_WDATA  in  8  write data
  o_RDATA  out  8  register read data
  o_RDATA_OE  out  1  o_RDATA valid
  o_SEL  out  16  one-hot target select, index = pslot*4 + sslot
  o_PAGE  out  2  current page, = i_A[15:14]
  o_MAP_SEG  out  MAP_W  mapper segment for current page
  i_TGT_BUSY  in  16  per-target busy, same indexing as o_SEL
  o_BUSY  out  1  CPU wait request

Function
REQ-006 The PSR (8 bits, 2 bits per page) SHALL be written once per access, on the first i_CLK cycle after the rising edge of (i_IORQ & i_WR & i_A[7:0]==A8h) is registered. This is a 2-FF edge detect, giving 2-cycle latency.
REQ-007 An A8h read SHALL drive o_RDATA = PSR with o_RDATA_OE=1 combinationally while i_IORQ & i_RD & i_A[7:0]==A8h.
REQ-008 The handling for an address in page 3 SHALL depend on p = PSR[7:6]:
  - If EXP_MASK[p]=1 and i_MERQ & i_A==FFFFh, the access targets SSR[p] (8 bits).
  - A write updates SSR[p] with the same edge rule as REQ-006.
  - A read returns ~SSR[p] with o_RDATA_OE=1.
  - o_SEL SHALL be 0 during this access.
REQ-009 If EXP_MASK[p]=0, FFFFh SHALL be decoded as ordinary memory.
REQ-010 With i_MERQ=1 and no FFFFh intercept:
  - pg = i_A[15:14], p = PSR[2pg+1:2pg].
  - s = EXP_MASK[p] ? SSR[p][2pg+1:2pg] : 0.
  - o_SEL SHALL be 1 at index p*4+s only, combinationally.
REQ-011 If i_IORQ and i_MERQ are both 1, i_IORQ SHALL win: o_SEL=0 and no SSR access.
REQ-012 Busy guard: on a rising edge of |o_SEL, o_BUSY SHALL assert from the next cycle for GUARD_CYC cycles.
REQ-013 o_BUSY SHALL be (guard active) | |(o_SEL & i_TGT_BUSY).
REQ-014 The guard counter SHALL clear when o_SEL falls to 0, and SHALL NOT retrigger while |o_SEL stays high.
REQ-015 If a target's busy is still asserted when the guard expires, o_BUSY SHALL stay high until that busy drops.
REQ-016 o_RDATA_OE SHALL be 0 and o_RDATA 8'h00 whenever no register read is decoded.
REQ-017 A write to A8h while i_MERQ is active SHALL change o_SEL only after the PSR update cycle, never mid-cycle.

Reset
REQ-018 On reset the following SHALL hold:
  - PSR=8'h00 and every SSR=8'h00.
  - Edge detectors and guard counter cleared.
  - o_BUSY=0, o_SEL=0, o_RDATA_OE=0.
  - Mapper registers FCh..FFh = 3,2,1,0.
REQ-019 A reset asserted mid-access SHALL abort the guard immediately. No register write SHALL occur in the reset cycle.

Configuration
REQ-020 Macro SLOT_SELECT_MAPPER_EN SHALL control the memory mapper, as follows.
REQ-021 When SLOT_SELECT_MAPPER_EN is defined:
  - I/O ports FCh..FFh hold the segments for pages 0..3 (MAP_W bits each), written per REQ-006.
  - A read returns {ones, seg} with o_RDATA_OE=1.
  - o_MAP_SEG = MAP[o_PAGE].
REQ-022 When SLOT_SELECT_MAPPER_EN is undefined:
  - FCh..FFh are not decoded and o_RDATA_OE stays 0 for them.
  - o_MAP_SEG = o_PAGE zero-extended.

Structure
REQ-023 Package slot_pkg SHALL hold:
  - IO_PSLOT=8'hA8, ADDR_SSR=16'hFFFF, IO_MAP_BASE=8'hFC.
  - typedef slot_id_t (4-bit {pslot,sslot}).
  - typedef page_t (2-bit).
REQ-024 The busy guard (edge detect plus counter) SHALL be a sub-module, slot_busy_guard.

Verification
REQ-025 Write A8h=8'hC0, then a MERQ read at C000h -> o_SEL[12]=1 (EXP_MASK=1000, SSR[3]=0).
REQ-026 With PSR=C0h, write FFFFh=8'h40, then read FFFFh -> o_RDATA=8'hBF, o_SEL=0. A subsequent access at C000h -> o_SEL[13]=1.
REQ-027 MERQ access at 4000h with PSR=0, i_TGT_BUSY=0 -> o_BUSY high for exactly GUARD_CYC=2 cycles. With i_TGT_BUSY[0] held 5 cycles -> o_BUSY high 5 cycles.
REQ-028 i_IORQ and i_MERQ both high with i_A=FFFFh and i_WR=1 -> SSR unchanged and o_SEL=0.
REQ-029 Mapper: write FEh=8'h05 with MAP_W=3, then read FEh -> 8'hFD; access at 8000h -> o_MAP_SEG=3'd5. With the macro undefined -> o_MAP_SEG=2, o_RDATA_OE=0.
REQ-030 Pulse reset during the busy guard -> o_BUSY=0 the next cycle; PSR reads 8'h00.
